// File: rtl/uart_rx_frontend.sv
// 8N1 UART receive front end: 2-FF synchroniser, mid-bit sampling FSM,
// single-entry valid/ready output buffer with framing-error and overrun pulses.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [2:0] WAIT_HIGH = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;

  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [2:0]  bitn;
  logic [7:0]  shreg;
  logic        rx_s1;
  logic        rxs;
  logic        stop_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b0;
      rxs   <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_HIGH;
      cnt       <= '0;
      bitn      <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        WAIT_HIGH: if (rxs) state <= IDLE;
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          cnt <= cnt + 16'd1;
          if (cnt == HALF_LAST) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              cnt   <= '0;
              bitn  <= '0;
            end
          end
        end
        DATA: begin
          cnt <= cnt + 16'd1;
          if (cnt == BIT_LAST) begin
            shreg <= {rxs, shreg[7:1]};
            cnt   <= '0;
            if (bitn == 3'd7) state <= STOP;
            else              bitn  <= bitn + 3'd1;
          end
        end
        STOP: begin
          cnt <= cnt + 16'd1;
          if (cnt == BIT_LAST) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              // Stop bit low (framing error or break): wait for idle line before re-arming.
              state     <= WAIT_HIGH;
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= WAIT_HIGH;
      endcase
    end
  end

  always_comb stop_ok = (state == STOP) && (cnt == BIT_LAST) && rxs;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (stop_ok) begin
        // An accept on the delivery edge frees the buffer for the new byte.
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at CLKS_PER_BIT=8: single byte latency,
// handshake hold, overrun, framing error/break, glitch rejection and mid-frame reset.
module tb_uart_rx_frontend;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  int unsigned cyc        = 0;
  int unsigned vhi_cnt    = 0;
  int unsigned fe_cnt     = 0;
  int unsigned ov_cnt     = 0;
  int unsigned rise_cyc   = 0;
  logic        prev_valid = 1'b0;
  int unsigned start_cyc  = 0;
  int unsigned vhi0, fe0, ov0;

  uart_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) vhi_cnt <= vhi_cnt + 1;
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= rx_valid;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
  end

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    #1;
    vhi0 = vhi_cnt;
    fe0  = fe_cnt;
    ov0  = ov_cnt;
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; optionally raises
  // rx_ready only on the stop-sample edge (edge 78 after the start edge).
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic ready_at_stop);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    start_cyc = cyc;
    for (int unsigned t = 0; t < 10 * CPB; t++) begin
      rx = frame[t / CPB];
      if (ready_at_stop) rx_ready = (t == 78);
      tick(1);
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    tick(3);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 8'h00);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 1);
    rst = 1'b0;
    tick(4);
    check("idle_busy", busy, 0);

    // 1: single byte with latency
    snap();
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(2);
    check("t1_data", rx_data, 8'hA5);
    check("t1_rise_edge", rise_cyc - start_cyc, 79);
    check("t1_valid_cycles", vhi_cnt - vhi0, 1);
    check("t1_frame_err", fe_cnt - fe0, 0);
    check("t1_overrun", ov_cnt - ov0, 0);

    // 2: handshake hold
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(5);
    check("t2_valid_held", rx_valid, 1);
    check("t2_data_held", rx_data, 8'h3C);
    rx_ready = 1'b1;
    tick(1);
    check("t2_valid_cleared", rx_valid, 0);
    rx_ready = 1'b0;
    tick(2);

    // 3: overrun, then delivery with same-edge drain
    snap();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(2);
    check("t3_overrun_pulses", ov_cnt - ov0, 1);
    check("t3_data_kept", rx_data, 8'h11);
    check("t3_valid", rx_valid, 1);
    snap();
    send_frame(8'h22, 1'b1, 1'b1);
    tick(2);
    check("t3_drain_data", rx_data, 8'h22);
    check("t3_drain_valid", rx_valid, 1);
    check("t3_drain_overrun", ov_cnt - ov0, 0);
    rx_ready = 1'b1;
    tick(1);
    check("t3_final_accept", rx_valid, 0);

    // 4: framing error followed by a break
    snap();
    send_frame(8'h55, 1'b0, 1'b0);
    rx = 1'b0;
    tick(40);
    check("t4_frame_err", fe_cnt - fe0, 1);
    check("t4_no_valid", vhi_cnt - vhi0, 0);
    check("t4_busy_break", busy, 1);
    rx = 1'b1;
    tick(4);
    check("t4_idle_after_high", busy, 0);
    snap();
    send_frame(8'h0F, 1'b1, 1'b0);
    tick(2);
    check("t4_next_data", rx_data, 8'h0F);
    check("t4_next_valid", vhi_cnt - vhi0, 1);

    // 5: glitch rejection
    snap();
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(2);
    check("t5_busy_start", busy, 1);
    tick(10);
    check("t5_back_idle", busy, 0);
    check("t5_no_valid", vhi_cnt - vhi0, 0);
    check("t5_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    check("t5_data_unchanged", rx_data, 8'h0F);

    // 6: reset mid-frame with line low
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(4 * CPB);
    rst = 1'b1;
    rx  = 1'b0;
    tick(3);
    rst = 1'b0;
    snap();
    check("t6_reset_data", rx_data, 8'h00);
    check("t6_reset_valid", rx_valid, 0);
    tick(20);
    check("t6_wait_high_busy", busy, 1);
    rx = 1'b1;
    tick(90);
    check("t6_no_byte", vhi_cnt - vhi0, 0);
    check("t6_no_frame_err", fe_cnt - fe0, 0);
    send_frame(8'h81, 1'b1, 1'b0);
    tick(2);
    check("t6_next_data", rx_data, 8'h81);
    check("t6_next_valid", vhi_cnt - vhi0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Serial receive front end of the UART-to-SPI bridge. Synchronises the asynchronous `rx` pin, detects and validates 8N1 frames by mid-bit sampling, and presents each received byte on a valid/ready handshake to the downstream SPI command stage. Single-entry output buffer; framing errors and overruns are reported as one-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 87, clock cycles per UART bit (10 MHz / 115200). Legal range 4..65535. `HALF` = `CLKS_PER_BIT` / 2, floor.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rx`  in  1  raw serial input, asynchronous, idle high.
- `rx_data`  out  8  received byte; stable while `rx_valid`=1.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  downstream accepts when `rx_valid` & `rx_ready` on a rising edge.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `overrun`  out  1  one-cycle pulse: completed byte dropped because the buffer was full.
- `busy`  out  1  high whenever FSM is not IDLE.

## Operation
- **Synchroniser:** 2 flip-flops on `rx`, both reset to 0. The FSM uses only the second stage, `rxs`.
- **Counter:** `cnt` is 16 bits. `bitn` is 3 bits. The shift register fills LSB first, so each sampled bit enters at bit 7 and shifts right.
- **FSM states:** WAIT_HIGH, IDLE, START, DATA, STOP.
  - WAIT_HIGH is the reset state. Moves to IDLE when `rxs`=1.
  - IDLE: when `rxs`=0, go to START with `cnt`=0.
  - START: increment `cnt`. When `cnt`=`HALF`-1, sample `rxs`.
    - 1 means a glitch: go to IDLE. No flags.
    - 0: go to DATA with `cnt`=0 and `bitn`=0.
  - DATA: increment `cnt`. When `cnt`=`CLKS_PER_BIT`-1, shift `rxs` in and clear `cnt`.
    - After the 8th bit (`bitn`=7) go to STOP.
    - Otherwise `bitn`++.
  - STOP: when `cnt`=`CLKS_PER_BIT`-1, sample `rxs`.
    - 1: deliver the byte (see below) and go to IDLE.
    - 0: pulse `frame_err`, discard the byte, and go to WAIT_HIGH. This covers break conditions: no new start is recognised until the line returns high.
- **Delivery**, on the edge where the stop bit is sampled 1:
  - If `rx_valid`=0, or `rx_valid` & `rx_ready` on that edge: load `rx_data` and set `rx_valid`=1.
  - If `rx_valid`=1 & `rx_ready`=0: keep the old byte, drop the new one, and pulse `overrun`.
- **Accept without a new byte:** `rx_valid` clears on the accepting edge.
- **Back-to-back frames:** a new start bit can be detected in the first IDLE cycle after STOP. There is no dead time beyond that.
- **Reset**, any time including mid-frame:
  - FSM goes to WAIT_HIGH; the partial frame is lost.
  - `rx_valid`=0, `rx_data`=0x00, `frame_err`=0, `overrun`=0.
  - Synchroniser goes to 0, `cnt`=0, `bitn`=0.
  - `busy`=1, because the FSM is not IDLE while in WAIT_HIGH.

## Timing
- **Latency:** cycle 0 is the first edge at which raw `rx` is sampled 0 by sync stage 1, with the FSM in IDLE. `rx_valid` is first seen high after edge 2 + `HALF` + 9·`CLKS_PER_BIT`. For `CLKS_PER_BIT`=8 this is edge 78.
- **Bit sampling:** data bit k is sampled `HALF` + (k+1)·`CLKS_PER_BIT` cycles after the IDLE→START transition, i.e. at mid-bit.
- **Flag pulses:** `frame_err` and `overrun` are registered and high for exactly 1 cycle, on the cycle after the stop-sample edge. This is the same cycle in which `rx_valid` would rise.
- **Output registers:** `rx_data` and `rx_valid` are registers with no combinational path from `rx_ready`.
- **Tolerance:** meets 8N1 with ±3% baud mismatch at `CLKS_PER_BIT` ≥ 16.

## Test plan
All scenarios use `CLKS_PER_BIT`=8.
1. **Reset and single byte:** assert reset, release with `rx` high, send 0xA5 with `rx_ready`=1 → `rx_data`=0xA5. `rx_valid` high for 1 cycle at edge 78 after the start edge. `frame_err` and `overrun` stay 0.
2. **Handshake hold:** send 0x3C with `rx_ready`=0 → `rx_valid` stays 1 and `rx_data`=0x3C stable. Raise `rx_ready` → `rx_valid` clears on the next edge.
3. **Overrun:** send 0x11 then 0x22 back-to-back with `rx_ready`=0 → one `overrun` pulse and `rx_data` remains 0x11. Then send 0x22 again with the buffer draining in the same cycle as delivery → 0x22 loaded, no `overrun`.
4. **Framing error / break:** send 0x55 with the stop bit 0, then hold `rx` low for 40 cycles → one `frame_err` pulse, no `rx_valid`, `busy`=1 until `rx` high. A following 0x0F is received correctly.
5. **Glitch rejection:** drive `rx` low for 2 cycles then high → FSM returns to IDLE, no flags, no `rx_valid`.
6. **Reset mid-frame:** assert reset during bit 4 of 0xFF while `rx` is low → after release no byte is delivered. The first valid frame after the line goes high (0x81) is received as 0x81.
